mem_ctrl: RTL and testbench

- Memory controller; the responder side of the byte-serial request/done protocol used by stage_if (instruction fetch) and stage_mem (loads and stores).
- Arbitrates the two requesters onto the single 8-bit RAM port.
- Sequences 1/2/4 byte accesses, assembling little-endian read words and splitting write words, then returns a one-cycle done pulse to the winning requester.

---
 rtl/mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requesters onto
// an 8-bit RAM port, assembling little-endian read words and splitting write words.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              own_mem_q, own_mem_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [2:0]        n_q, n_d, idx_q, idx_d, idx_p1;
  logic [DATA_W-1:0] wdata_q, wdata_d, asm_q, asm_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic [1:0]        byte_sel;

  always_comb begin
    state_d     = state_q;
    own_mem_d   = own_mem_q;
    base_d      = base_q;
    addr_d      = addr_q;
    n_d         = n_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    byte_sel    = '0;
    idx_p1      = idx_q + 3'd1;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        asm_d = '0;
        if (mem_req_i) begin
          own_mem_d = 1'b1;
          base_d    = mem_addr_i;
          addr_d    = mem_addr_i;
          n_d       = (mem_len_i == 2'b00) ? 3'd1 : (mem_len_i == 2'b01) ? 3'd2 : 3'd4;
          wdata_d   = mem_wdata_i;
          if (mem_we_i) begin
            state_d = S_WRITE;
            dout_d  = mem_wdata_i[7:0];
            wr_d    = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end else if (if_req_i && !if_flush_i) begin
          own_mem_d = 1'b0;
          base_d    = if_addr_i;
          addr_d    = if_addr_i;
          n_d       = 3'd4;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (!own_mem_q && if_flush_i) begin
          state_d = S_IDLE;
        end else begin
          // RAM data lags the address by one cycle, so index i fills byte i-1
          if (idx_q != 3'd0) begin
            byte_sel = idx_q[1:0] - 2'd1;
            asm_d[{byte_sel, 3'b000} +: 8] = ram_din_i;
          end
          if (idx_q < n_q - 3'd1) addr_d = base_q + ADDR_W'(idx_p1);
          if (idx_q == n_q) begin
            state_d = S_DONE;
            if (own_mem_q) mem_rdata_d = asm_d;
            else           if_data_d   = asm_d;
          end else begin
            idx_d = idx_p1;
          end
        end
      end
      S_WRITE: begin
        if (idx_q < n_q - 3'd1) begin
          idx_d    = idx_p1;
          addr_d   = base_q + ADDR_W'(idx_p1);
          byte_sel = idx_p1[1:0];
          dout_d   = wdata_q[{byte_sel, 3'b000} +: 8];
        end else begin
          wr_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      own_mem_q   <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      own_mem_q   <= own_mem_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
    end
  end

  assign if_done_o   = (state_q == S_DONE) && !own_mem_q;
  assign mem_done_o  = (state_q == S_DONE) && own_mem_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_dout_o  = dout_q;
  assign ram_addr_o  = addr_q;
  assign ram_wr_o    = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-addressed RAM model, shadow-memory reference
// and a done-pulse monitor checking owner, data and completion cycle.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_data_o;
  logic        mem_req_i, mem_we_i, mem_done_o;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [7:0]  ram_din_i, ram_dout_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Physical RAM seen by the DUT; frozen along with everything else while rdy=0
  bit [7:0] ram    [bit [31:0]];
  bit [7:0] shadow [bit [31:0]];

  function automatic bit [7:0] ram_rd(input bit [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  function automatic bit [7:0] sh_rd(input bit [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      ram_din_i <= ram_rd(ram_addr_o);
      if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;
    end
  end

  function automatic void preload(input bit [31:0] a, input bit [7:0] b);
    ram[a]    = b;
    shadow[a] = b;
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input bit [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r = r | (32'(sh_rd(a + 32'(k))) << (8 * k));
    return r;
  endfunction

  function automatic void model_store(input bit [31:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) shadow[a + 32'(k)] = 8'(d >> (8 * k));
  endfunction

  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
    int          done_cyc;
  } exp_t;
  exp_t sbq[$];

  // Completion cycle: read finishes N+1 edges after the accepting edge, write N.
  function automatic int done_at(input int accept, input int n, input bit we, input int stall);
    return accept + n + (we ? 0 : 1) + stall;
  endfunction

  always @(negedge clk) begin
    if (!rdy) chk("ram_wr_while_stalled", 32'(ram_wr_o), 32'd0);
    if (if_done_o || mem_done_o) begin
      if (if_done_o && mem_done_o) chk("both_done", 32'd1, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", {30'd0, mem_done_o, if_done_o}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_owner", 32'(mem_done_o), 32'(e.is_mem));
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        if (e.chk_data) chk(e.is_mem ? "mem_rdata" : "if_data",
                            e.is_mem ? mem_rdata_o : if_data_o, e.data);
      end
    end
  end

  task automatic wait_done(input bit need_if, input bit need_mem);
    bit gi, gm;
    gi = !need_if;
    gm = !need_mem;
    for (int t = 0; t < 80 && !(gi && gm); t++) begin
      @(negedge clk);
      if (if_done_o)  gi = 1'b1;
      if (mem_done_o) gm = 1'b1;
      @(posedge clk); #1;
      if (gi) if_req_i  = 1'b0;
      if (gm) mem_req_i = 1'b0;
    end
    if (!(gi && gm)) begin
      chk("done_timeout", {30'd0, gm, gi}, 32'd3);
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
    end
  endtask

  task automatic stall(input int len);
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (len) begin @(posedge clk); #1; end
    rdy = 1'b1;
  endtask

  // Called #1 after an edge with the controller idle; accepted on the next edge.
  task automatic do_mem(input bit we, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, input int st);
    exp_t e;
    int n = nbytes(len);
    e.is_mem   = 1'b1;
    e.chk_data = !we;
    e.done_cyc = done_at(cyc + 1, n, we, st);
    if (we) begin
      model_store(a, n, wd);
      e.data = '0;
    end else begin
      e.data = model_load(a, n);
    end
    sbq.push_back(e);
    mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = a; mem_wdata_i = wd;
    if (st > 0) stall(st);
    wait_done(1'b0, 1'b1);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int st);
    exp_t e;
    e.is_mem   = 1'b0;
    e.chk_data = 1'b1;
    e.data     = model_load(a, 4);
    e.done_cyc = done_at(cyc + 1, 4, 1'b0, st);
    sbq.push_back(e);
    if_req_i = 1'b1; if_addr_i = a;
    if (st > 0) stall(st);
    wait_done(1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, e2;
    logic [31:0] a, d;
    rst = 1'b0; rdy = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h100; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00;
    mem_addr_i = '0; mem_wdata_i = '0;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    preload(32'h104, 8'h93); preload(32'h105, 8'h00);
    preload(32'h106, 8'h20); preload(32'h107, 8'h00);
    preload(32'h40, 8'h7F);

    // Reset held with a pending fetch: nothing moves
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", if_data_o | mem_rdata_o | 32'(ram_dout_o) | ram_addr_o, 32'd0);
      chk("reset_ctrl", {29'd0, if_done_o, mem_done_o, ram_wr_o}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    e.is_mem = 1'b0; e.chk_data = 1'b1; e.data = 32'h00100513;
    e.done_cyc = done_at(cyc + 1, 4, 1'b0, 0);
    sbq.push_back(e);
    @(posedge clk); #1;
    chk("first_ram_addr", ram_addr_o, 32'h100);
    wait_done(1'b1, 1'b0);

    // Store word then load half
    do_mem(1'b1, 2'b10, 32'h20, 32'hDEADBEEF, 0);
    do_mem(1'b0, 2'b01, 32'h22, 32'h0, 0);
    chk("store_byte0", 32'(ram_rd(32'h20)), 32'hEF);

    // Simultaneous requests: MEM wins, IF accepted in the IDLE after DONE
    e.is_mem = 1'b1; e.chk_data = 1'b1; e.data = 32'h7F;
    e.done_cyc = done_at(cyc + 1, 1, 1'b0, 0);
    e2.is_mem = 1'b0; e2.chk_data = 1'b1; e2.data = model_load(32'h100, 4);
    e2.done_cyc = done_at(e.done_cyc + 2, 4, 1'b0, 0);
    sbq.push_back(e); sbq.push_back(e2);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h40;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    wait_done(1'b1, 1'b1);

    // Flush at READ i=2, then fetch the branch target
    if_req_i = 1'b1; if_addr_i = 32'h300;
    repeat (3) begin @(posedge clk); #1; end
    if_flush_i = 1'b1; if_req_i = 1'b0;
    @(posedge clk); #1;
    if_flush_i = 1'b0;
    do_fetch(32'h104, 0);

    // Flush in IDLE blocks the fetch that cycle only
    if_flush_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h104;
    @(posedge clk); #1;
    if_flush_i = 1'b0;
    do_fetch(32'h104, 0);

    // rdy stall with address wrap, and a stalled store
    preload(32'hFFFFFFFE, 8'hA1); preload(32'hFFFFFFFF, 8'hB2);
    preload(32'h0, 8'hC3); preload(32'h1, 8'hD4);
    do_mem(1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 2);
    do_mem(1'b1, 2'b11, 32'hFFFFFFFF, 32'h11223344, 2);
    do_mem(1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 0);

    // Randomised mix of fetches, loads and stores
    for (int it = 0; it < 60; it++) begin
      int kind, st;
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h200 + 32'($urandom_range(0, 63));
      d = $urandom;
      st = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      if (kind == 0) do_fetch(a, st);
      else           do_mem(kind == 2, 2'($urandom_range(0, 3)), a, d, st);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    foreach (shadow[k]) chk("ram_final", 32'(ram_rd(k)), 32'(shadow[k]));
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
